rr_arbiter_wburst: RTL and testbench

//  N-requester round-robin arbiter with per-channel weighted burst grants.

---
 rtl/arb_pkg.sv | 34 +++
 rtl/rr_arbiter_wburst_pick.sv | 45 ++++
 rtl/rr_arbiter_wburst.sv | 107 ++++++++++
 tb/tb_rr_arbiter_wburst.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared arbiter types and helpers: FSM state encoding, constant clog2 and
// one-hot to binary index conversion.
`default_nettype none

package arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Never returns less than 1 so that an index port always has a bit.
  function automatic int arb_clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // OR of the indices of the set bits; exact for a one-hot or zero input.
  function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) r = r | 5'(i);
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter_wburst_pick.sv
// Rotating-priority picker: lowest requester at or above i_ptr, otherwise the
// lowest requester overall (masked double-priority search).
`default_nettype none

module rr_pick
  import arb_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = arb_clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_found,
  output logic [IDX_W-1:0] o_win_idx,
  output logic [N-1:0]     o_win_onehot
);

  logic [N-1:0] w_mask;
  logic [N-1:0] w_masked;
  logic [N-1:0] w_hi_oh;
  logic [N-1:0] w_lo_oh;

  for (genvar i = 0; i < N; i++) begin : g_mask
    assign w_mask[i] = (IDX_W'(i) >= i_ptr);
  end

  assign w_masked = i_req & w_mask;

  // x & -x isolates the lowest set bit.
  assign w_hi_oh = w_masked & (-w_masked);
  assign w_lo_oh = i_req & (-i_req);

  assign o_found      = |i_req;
  assign o_win_onehot = (|w_masked) ? w_hi_oh : w_lo_oh;

  always_comb begin
    o_win_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (o_win_onehot[i]) o_win_idx = o_win_idx | IDX_W'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter_wburst.sv
// N-way round-robin arbiter; the winner keeps the grant for up to its sampled
// burst weight while it holds its request, then priority rotates.
`default_nettype none

module rr_arbiter_wburst
  import arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int WEIGHT_W = 4,
  localparam int IDX_W    = arb_clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          i_req,
  input  logic [N*WEIGHT_W-1:0] i_weight,
  output logic [N-1:0]          o_gnt,
  output logic                  o_gnt_valid,
  output logic [IDX_W-1:0]      o_gnt_idx
);

  localparam logic [0:0] ST_IDLE  = ARB_IDLE;
  localparam logic [0:0] ST_GRANT = ARB_GRANT;

  logic [0:0]          r_state;
  logic [IDX_W-1:0]    r_last_owner;
  logic [WEIGHT_W-1:0] r_cnt;
  logic [WEIGHT_W-1:0] r_weff;
  logic [N-1:0]        r_gnt;
  logic                r_gnt_valid;
  logic [IDX_W-1:0]    r_gnt_idx;

  logic [IDX_W-1:0]    w_base;
  logic [IDX_W-1:0]    w_ptr;
  logic                w_found;
  logic [IDX_W-1:0]    w_win_idx;
  logic [N-1:0]        w_win_oh;
  logic [WEIGHT_W-1:0] w_wsel;
  logic [WEIGHT_W-1:0] w_new_weff;
  logic                w_in_grant;
  logic                w_continue;
  logic                w_burst_end;
  logic                w_load;

  // In GRANT the owner is the pointer base, so it is searched last.
  assign w_base = (r_state == ST_GRANT) ? r_gnt_idx : r_last_owner;
  assign w_ptr  = (w_base == IDX_W'(N - 1)) ? '0 : w_base + IDX_W'(1);

  rr_pick #(.N(N)) u_pick (
    .i_req        (i_req),
    .i_ptr        (w_ptr),
    .o_found      (w_found),
    .o_win_idx    (w_win_idx),
    .o_win_onehot (w_win_oh)
  );

  always_comb begin
    w_wsel = '0;
    for (int i = 0; i < N; i++) begin
      if (w_win_idx == IDX_W'(i)) w_wsel = i_weight[i*WEIGHT_W +: WEIGHT_W];
    end
  end

  assign w_new_weff  = (w_wsel == '0) ? WEIGHT_W'(1) : w_wsel;
  assign w_in_grant  = (r_state == ST_GRANT);
  assign w_continue  = (|(i_req & r_gnt)) && (r_cnt < (r_weff - WEIGHT_W'(1)));
  assign w_burst_end = w_in_grant && !w_continue;
  assign w_load      = w_found && ((r_state == ST_IDLE) || w_burst_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last_owner <= IDX_W'(N - 1);
      r_cnt        <= '0;
      r_weff       <= '0;
      r_gnt        <= '0;
      r_gnt_valid  <= 1'b0;
      r_gnt_idx    <= '0;
    end else begin
      if (w_burst_end) r_last_owner <= r_gnt_idx;

      if (w_load) begin
        r_state     <= ST_GRANT;
        r_gnt       <= w_win_oh;
        r_gnt_idx   <= w_win_idx;
        r_gnt_valid <= 1'b1;
        r_cnt       <= '0;
        r_weff      <= w_new_weff;
      end else if (w_in_grant && w_continue) begin
        r_cnt <= r_cnt + WEIGHT_W'(1);
      end else if (r_state != ST_IDLE) begin
        // Burst ended with nobody waiting, or an unknown state: drop to idle.
        r_state     <= ST_IDLE;
        r_gnt       <= '0;
        r_gnt_idx   <= '0;
        r_gnt_valid <= 1'b0;
        r_cnt       <= '0;
      end
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_valid = r_gnt_valid;
  assign o_gnt_idx   = r_gnt_idx;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_wburst.sv
// Directed and constrained-random bench for rr_arbiter_wburst (N=4, WEIGHT_W=4).
`default_nettype none

module tb_rr_arbiter_wburst;

  logic        clk;
  logic        rst_n;
  logic [3:0]  i_req;
  logic [15:0] i_weight;
  logic [3:0]  o_gnt;
  logic        o_gnt_valid;
  logic [1:0]  o_gnt_idx;

  int n_chk;
  int n_fail;

  rr_arbiter_wburst #(.N(4), .WEIGHT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (i_req),
    .i_weight    (i_weight),
    .o_gnt       (o_gnt),
    .o_gnt_valid (o_gnt_valid),
    .o_gnt_idx   (o_gnt_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] idx_of(input logic [3:0] oh);
    logic [31:0] r;
    r = 0;
    for (int i = 3; i >= 0; i--) begin
      if (oh[i]) r = i;
    end
    return r;
  endfunction

  task automatic chk_gnt(input string tag, input logic [3:0] exp_oh);
    chk({tag, ".gnt"}, 32'(o_gnt), 32'(exp_oh));
    chk({tag, ".valid"}, 32'(o_gnt_valid), 32'(exp_oh != 4'b0000));
    chk({tag, ".idx"}, 32'(o_gnt_idx), idx_of(exp_oh));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] req, input logic [15:0] wt);
    @(negedge clk);
    rst_n    = 1'b0;
    i_req    = req;
    i_weight = wt;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0] exp_seq [10];
  int         waitc   [4];
  int         bound   [4];
  int         wv      [4];

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    i_req    = 4'b0000;
    i_weight = 16'h1111;

    // Reset holds outputs low even with every channel requesting.
    @(negedge clk);
    rst_n = 1'b0;
    i_req = 4'b1111;
    tick();
    chk_gnt("reset", 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_gnt($sformatf("rr_w1[%0d]", k), 4'(1 << (k % 4)));
    end

    // Weights ch0..ch3 = 3,2,1,0; weight 0 behaves as 1.
    exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010,
                4'b0100, 4'b1000, 4'b0001, 4'b0001, 4'b0001};
    do_reset(4'b1111, {4'd0, 4'd1, 4'd2, 4'd3});
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_gnt($sformatf("burst[%0d]", k), exp_seq[k]);
    end

    // Early drop: ch1 (weight 5) drops during its third granted cycle.
    do_reset(4'b0110, {4'd1, 4'd1, 4'd5, 4'd1});
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_gnt($sformatf("drop_hold[%0d]", k), 4'b0010);
    end
    i_req = 4'b0100;
    tick();
    chk_gnt("drop_move", 4'b0100);
    tick();
    chk_gnt("drop_lone", 4'b0100);

    // Lone requester ch2 with weight 2: continuous grant, counter reloads.
    do_reset(4'b0100, {4'd1, 4'd2, 4'd1, 4'd1});
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_gnt($sformatf("lone[%0d]", k), 4'b0100);
      chk($sformatf("lone_cnt[%0d]", k), 32'(dut.r_cnt), 32'(k % 2));
    end

    // Wrap-around after ch3 and re-grant of a lone ch3.
    do_reset(4'b1000, 16'h1111);
    tick();
    chk_gnt("wrap_ch3", 4'b1000);
    i_req = 4'b1001;
    tick();
    chk_gnt("wrap_ch0", 4'b0001);
    i_req = 4'b1000;
    tick();
    chk_gnt("wrap_back3", 4'b1000);
    tick();
    chk_gnt("wrap_regrant3", 4'b1000);
    i_req = 4'b0000;
    tick();
    chk_gnt("wrap_idle", 4'b0000);
    i_req = 4'b0001;
    tick();
    chk_gnt("wrap_from_idle", 4'b0001);

    // Async reset mid-burst with last_owner = 1, so only a reset pointer picks ch1.
    i_weight = {4'd1, 4'd5, 4'd1, 4'd1};
    i_req    = 4'b0010;
    tick();
    chk_gnt("ar_ch1", 4'b0010);
    i_req = 4'b0100;
    tick();
    chk_gnt("ar_ch2a", 4'b0100);
    tick();
    chk_gnt("ar_ch2b", 4'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    chk_gnt("ar_async", 4'b0000);
    i_req = 4'b0110;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_gnt("ar_after", 4'b0010);

    // Random traffic: invariants and wait bound; req held until granted.
    for (int i = 0; i < 4; i++) wv[i] = $urandom_range(3, 0);
    do_reset(4'b0000, {4'(wv[3]), 4'(wv[2]), 4'(wv[1]), 4'(wv[0])});
    for (int i = 0; i < 4; i++) begin
      waitc[i] = 0;
      bound[i] = 1;
      for (int j = 0; j < 4; j++) begin
        if (j != i) bound[i] += (wv[j] == 0) ? 1 : wv[j];
      end
    end
    for (int c = 0; c < 300; c++) begin
      tick();
      chk("inv_onehot0", 32'($onehot0(o_gnt)), 32'd1);
      chk("inv_valid", 32'(o_gnt_valid), 32'(|o_gnt));
      chk("inv_idx", 32'(o_gnt_idx), idx_of(o_gnt));
      for (int i = 0; i < 4; i++) begin
        if (i_req[i] && !o_gnt[i]) waitc[i]++;
        else waitc[i] = 0;
        chk($sformatf("starve_ch%0d", i), 32'(waitc[i] <= bound[i]), 32'd1);
      end
      for (int i = 0; i < 4; i++) begin
        if (!i_req[i]) i_req[i] = 1'($urandom_range(1, 0));
        else if (o_gnt[i] && ($urandom_range(2, 0) == 0)) i_req[i] = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
